lcd_hex_display: RTL and testbench

- Parametrised successor to the team's single-digit LCD result display.
- Drives the Spartan-3E 16x2 character LCD through its 4-bit write-only interface, using a proper timed power-on init FSM instead of a free-running counter.
- Renders a DATA_W-bit value as NUM_DIGITS upper-case hex characters, with an optional signed (sign + magnitude) mode, starting at a chosen DDRAM address.
- Sits beside the processor datapath; the top level pulses update whenever the result register changes.

---
 rtl/lcd_hex_display.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_lcd_hex_display.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hex_display.sv
// Spartan-3E 16x2 character LCD driver: timed power-on init, then renders a
// DATA_W-bit value as upper-case hex (optionally sign + magnitude) on request.
module lcd_hex_display #(
  parameter int unsigned DATA_W        = 16,
  parameter logic [6:0]  START_ADDR    = 7'h00,
  parameter int unsigned INIT_WAIT     = 750000,
  parameter int unsigned INIT_NIB_WAIT = 205000,
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned E_CYC         = 12,
  parameter int unsigned GAP_CYC       = 50,
  parameter int unsigned CMD_WAIT      = 2000,
  parameter int unsigned CLEAR_WAIT    = 82000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              signed_en,
  input  logic              update,
  output logic              busy,
  output logic              init_done,
  output logic              sf_e,
  output logic              lcd_e,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic [3:0]        lcd_d
);

  localparam int unsigned NUM_DIGITS = (DATA_W + 3) / 4;
  localparam int unsigned DIGW       = NUM_DIGITS * 4;
  localparam logic [7:0]  LAST_DIGIT = 8'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    POWER_WAIT, INIT_NIB, INIT_BYTES, IDLE, SET_ADDR, WR_SIGN, WR_DIGIT
  } state_t;

  typedef enum logic [2:0] {
    PH_START, PH_SETUP, PH_E, PH_HOLD, PH_GAP, PH_WAIT
  } phase_t;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       lim_q, lim_d;
  logic [7:0]        idx_q, idx_d;
  logic              hi_q, hi_d;
  logic              lcd_e_q, lcd_e_d;
  logic              lcd_rs_q, lcd_rs_d;
  logic [3:0]        lcd_d_q, lcd_d_d;
  logic              busy_q, busy_d;
  logic              init_done_q, init_done_d;
  logic              pending_q, pending_d;
  logic              sgn_q, sgn_d;
  logic              neg_q, neg_d;
  logic [DIGW-1:0]   disp_q, disp_d;

  logic [7:0]        cur_byte;
  logic              cur_rs;
  logic              nib_only;
  logic [3:0]        digit;
  logic [DATA_W:0]   mag;
  logic [DIGW-1:0]   disp_new;
  logic              item_done;
  logic              start_rd;

  // Magnitude is one bit wider so the most-negative value negates without overflow
  always_comb begin
    mag = {1'b0, value};
    if (signed_en && value[DATA_W-1]) mag = {1'b0, ~value} + 1'b1;
    disp_new = DIGW'(mag);
  end

  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    nib_only = 1'b0;
    digit    = 4'(disp_q >> (4 * (LAST_DIGIT - idx_q)));
    case (state_q)
      INIT_NIB: begin
        nib_only = 1'b1;
        cur_byte = (idx_q < 8'd3) ? 8'h03 : 8'h02;
      end
      INIT_BYTES: begin
        case (idx_q[1:0])
          2'd0:    cur_byte = 8'h28;
          2'd1:    cur_byte = 8'h06;
          2'd2:    cur_byte = 8'h0C;
          default: cur_byte = 8'h01;
        endcase
      end
      SET_ADDR: cur_byte = {1'b1, START_ADDR};
      WR_SIGN: begin
        cur_rs   = 1'b1;
        cur_byte = neg_q ? 8'h2D : 8'h20;
      end
      WR_DIGIT: begin
        cur_rs   = 1'b1;
        cur_byte = (digit < 4'd10) ? (8'h30 + {4'h0, digit}) : (8'h37 + {4'h0, digit});
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    lcd_e_d     = lcd_e_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_d_d     = lcd_d_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    pending_d   = pending_q;
    sgn_d       = sgn_q;
    neg_d       = neg_q;
    disp_d      = disp_q;
    item_done   = 1'b0;
    start_rd    = 1'b0;

    if (update && busy_q) pending_d = 1'b1;

    case (state_q)
      POWER_WAIT: begin
        if (cnt_q + 1 >= INIT_WAIT) begin
          state_d = INIT_NIB;
          phase_d = PH_START;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      IDLE: begin
        if (update || pending_q) start_rd = 1'b1;
      end
      default: begin
        case (phase_q)
          PH_START: begin
            lcd_d_d  = nib_only ? cur_byte[3:0] : cur_byte[7:4];
            lcd_rs_d = cur_rs;
            hi_d     = !nib_only;
            cnt_d    = '0;
            phase_d  = PH_SETUP;
          end
          PH_SETUP: begin
            if (cnt_q + 1 >= SETUP_CYC) begin
              lcd_e_d = 1'b1;
              cnt_d   = '0;
              phase_d = PH_E;
            end else begin
              cnt_d = cnt_q + 1;
            end
          end
          PH_E: begin
            if (cnt_q + 1 >= E_CYC) begin
              lcd_e_d = 1'b0;
              cnt_d   = '0;
              phase_d = PH_HOLD;
            end else begin
              cnt_d = cnt_q + 1;
            end
          end
          PH_HOLD: begin
            cnt_d = '0;
            if (hi_q) begin
              phase_d = PH_GAP;
            end else begin
              phase_d = PH_WAIT;
              if (nib_only)
                lim_d = (idx_q < 8'd3) ? INIT_NIB_WAIT : CMD_WAIT;
              else if (!cur_rs && cur_byte == 8'h01)
                lim_d = CLEAR_WAIT;
              else
                lim_d = CMD_WAIT;
            end
          end
          PH_GAP: begin
            if (cnt_q + 1 >= GAP_CYC) begin
              lcd_d_d = cur_byte[3:0];
              hi_d    = 1'b0;
              cnt_d   = '0;
              phase_d = PH_SETUP;
            end else begin
              cnt_d = cnt_q + 1;
            end
          end
          PH_WAIT: begin
            if (cnt_q + 1 >= lim_q) item_done = 1'b1;
            else                    cnt_d = cnt_q + 1;
          end
          default: phase_d = PH_START;
        endcase
      end
    endcase

    if (item_done) begin
      phase_d = PH_START;
      cnt_d   = '0;
      case (state_q)
        INIT_NIB: begin
          if (idx_q < 8'd3) idx_d = idx_q + 8'd1;
          else begin
            state_d = INIT_BYTES;
            idx_d   = '0;
          end
        end
        INIT_BYTES: begin
          if (idx_q < 8'd3) idx_d = idx_q + 8'd1;
          else begin
            init_done_d = 1'b1;
            if (pending_q || update) start_rd = 1'b1;
            else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        SET_ADDR: begin
          state_d = sgn_q ? WR_SIGN : WR_DIGIT;
          idx_d   = '0;
        end
        WR_SIGN: begin
          state_d = WR_DIGIT;
          idx_d   = '0;
        end
        WR_DIGIT: begin
          if (idx_q < LAST_DIGIT) idx_d = idx_q + 8'd1;
          else if (pending_q || update) start_rd = 1'b1;
          else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A request arriving on the cycle a redraw starts is absorbed by that redraw
    if (start_rd) begin
      state_d   = SET_ADDR;
      phase_d   = PH_START;
      cnt_d     = '0;
      idx_d     = '0;
      busy_d    = 1'b1;
      pending_d = 1'b0;
      sgn_d     = signed_en;
      neg_d     = signed_en && value[DATA_W-1];
      disp_d    = disp_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= POWER_WAIT;
      phase_q     <= PH_START;
      cnt_q       <= '0;
      lim_q       <= '0;
      idx_q       <= '0;
      hi_q        <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_d_q     <= '0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      pending_q   <= 1'b0;
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_d_q     <= lcd_d_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      pending_q   <= pending_d;
      sgn_q       <= sgn_d;
      neg_q       <= neg_d;
      disp_q      <= disp_d;
    end
  end

  assign sf_e      = 1'b1;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_d     = lcd_d_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_hex_display.sv
// Scoreboard bench for lcd_hex_display: expected nibbles are queued when
// stimulus is applied and popped on every lcd_e rising edge.
module tb_lcd_hex_display;

  localparam int unsigned DATA_W        = 16;
  localparam logic [6:0]  START_ADDR    = 7'h00;
  localparam int unsigned INIT_WAIT     = 20;
  localparam int unsigned INIT_NIB_WAIT = 10;
  localparam int unsigned SETUP_CYC     = 2;
  localparam int unsigned E_CYC         = 2;
  localparam int unsigned GAP_CYC       = 3;
  localparam int unsigned CMD_WAIT      = 5;
  localparam int unsigned CLEAR_WAIT    = 8;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] value;
  logic              signed_en;
  logic              update;
  logic              busy;
  logic              init_done;
  logic              sf_e;
  logic              lcd_e;
  logic              lcd_rs;
  logic              lcd_rw;
  logic [3:0]        lcd_d;

  lcd_hex_display #(
    .DATA_W(DATA_W), .START_ADDR(START_ADDR), .INIT_WAIT(INIT_WAIT),
    .INIT_NIB_WAIT(INIT_NIB_WAIT), .SETUP_CYC(SETUP_CYC), .E_CYC(E_CYC),
    .GAP_CYC(GAP_CYC), .CMD_WAIT(CMD_WAIT), .CLEAR_WAIT(CLEAR_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .signed_en(signed_en), .update(update),
    .busy(busy), .init_done(init_done), .sf_e(sf_e), .lcd_e(lcd_e),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] n);
    exp_t e;
    e.rs  = rs;
    e.nib = n;
    exp_q.push_back(e);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    push_nib(rs, b[7:4]);
    push_nib(rs, b[3:0]);
  endtask

  task automatic push_init();
    for (int i = 0; i < 3; i++) push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h2);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    if (d <= 4'd9) return 8'h30 + {4'h0, d};
    return 8'h41 + {4'h0, d} - 8'd10;
  endfunction

  task automatic push_redraw(input logic [15:0] v, input logic s);
    logic [16:0] m;
    push_byte(1'b0, {1'b1, START_ADDR});
    if (s) push_byte(1'b1, v[15] ? 8'h2D : 8'h20);
    m = (s && v[15]) ? (17'h10000 - {1'b0, v}) : {1'b0, v};
    for (int i = 3; i >= 0; i--) push_byte(1'b1, hex_char(m[i*4 +: 4]));
  endtask

  // Monitor: pops one expected nibble per lcd_e rise and checks setup time
  logic [4:0] prev_bus;
  logic       prev_e;
  int         stable;
  int         since_e;

  always @(negedge clk) begin
    logic [4:0] cur;
    exp_t       e;
    if (rst) begin
      prev_e   = 1'b0;
      prev_bus = '0;
      stable   = 0;
      since_e  = 0;
    end else begin
      cur = {lcd_rs, lcd_d};
      if (lcd_e && !prev_e) begin
        chk("setup_time", (cur == prev_bus && stable >= int'(SETUP_CYC)) ? 32'd1 : 32'd0, 32'd1);
        chk("sf_e_high", {31'd0, sf_e}, 32'd1);
        chk("lcd_rw_low", {31'd0, lcd_rw}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("rs_nibble", {27'd0, cur}, {27'd0, e.rs, e.nib});
        end
      end
      if (cur == prev_bus) stable++;
      else stable = 1;
      prev_bus = cur;
      if (lcd_e) since_e = 0;
      else since_e++;
      prev_e = lcd_e;
    end
  end

  task automatic do_update(input logic [15:0] v, input logic s);
    value     = v;
    signed_en = s;
    update    = 1'b1;
    @(negedge clk);
    update = 1'b0;
    chk("busy_after_update", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
  endtask

  task automatic wait_redraw_done(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_fell"}, {31'd0, busy}, 32'd0);
    chk({tag, "_drained"}, exp_q.size(), 32'd0);
    chk({tag, "_cmd_wait"},
        (since_e >= int'(CMD_WAIT) + 1 && since_e <= int'(CMD_WAIT) + 3) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    value     = '0;
    signed_en = 1'b0;
    update    = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_lcd_d", {28'd0, lcd_d}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_sf_e", {31'd0, sf_e}, 32'd1);
    chk("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);

    repeat (3) @(negedge clk);
    push_init();
    rst = 1'b0;
    wait_init("init");
    chk("init_busy_low", {31'd0, busy}, 32'd0);
    chk("init_drained", exp_q.size(), 32'd0);
    chk("init_clear_wait",
        (since_e >= int'(CLEAR_WAIT) + 1 && since_e <= int'(CLEAR_WAIT) + 3) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);

    push_redraw(16'h1A2F, 1'b0);
    do_update(16'h1A2F, 1'b0);
    wait_redraw_done("u_1a2f");
    repeat (3) @(negedge clk);

    push_redraw(16'hFFFE, 1'b1);
    do_update(16'hFFFE, 1'b1);
    wait_redraw_done("s_fffe");
    push_redraw(16'h8000, 1'b1);
    do_update(16'h8000, 1'b1);
    wait_redraw_done("s_8000");
    push_redraw(16'h0005, 1'b1);
    do_update(16'h0005, 1'b1);
    wait_redraw_done("s_0005");
    @(negedge clk);

    push_redraw(16'h0001, 1'b0);
    push_redraw(16'h0003, 1'b0);
    do_update(16'h0001, 1'b0);
    repeat (10) @(negedge clk);
    do_update(16'h0002, 1'b0);
    repeat (15) @(negedge clk);
    do_update(16'h0007, 1'b0);
    repeat (15) @(negedge clk);
    do_update(16'h0003, 1'b0);
    wait_redraw_done("b2b");

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    push_init();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    push_redraw(16'h00C4, 1'b0);
    do_update(16'h00C4, 1'b0);
    wait_init("pend");
    chk("pend_busy_held", {31'd0, busy}, 32'd1);
    wait_redraw_done("pend");

    push_redraw(16'h1234, 1'b0);
    do_update(16'h1234, 1'b0);
    n = 0;
    while (!(exp_q.size() <= 5 && lcd_e) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_digit_reached", {31'd0, lcd_e}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_init_done", {31'd0, init_done}, 32'd0);
    exp_q.delete();
    push_init();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_init("reinit");
    chk("reinit_drained", exp_q.size(), 32'd0);
    chk("reinit_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);

    push_redraw(16'h7FFF, 1'b1);
    do_update(16'h7FFF, 1'b1);
    wait_redraw_done("s_7fff");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
